// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX-stage branch/jump resolver with a 2-bit saturating-counter BHT
// for fetch prediction, a registered redirect pulse and saturating perf counters.
module branch_predict_unit #(
   parameter int          XLEN        = 32,
   parameter int          BHT_ENTRIES = 64,
   parameter int          IMM_SHIFT   = 2,
   parameter int          PC_INC      = 1,
   parameter logic [1:0]  CTR_INIT    = 2'b01,
   parameter int          CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  f_pc,
   output logic             f_pred_taken,
   input  logic             ex_valid,
   input  logic             stall,
   input  logic             ex_jal,
   input  logic             ex_jalr,
   input  logic             ex_branch,
   input  logic [2:0]       ex_funct3,
   input  logic             ex_zero,
   input  logic             ex_lt,
   input  logic             ex_ltu,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_alu_result,
   input  logic             ex_pred_taken,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             jump,
   output logic [XLEN-1:0]  next,
   output logic             out_jal,
   output logic             out_jalr,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mispred_count
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht [BHT_ENTRIES];
   logic             acc, cond, taken, need_redirect;
   logic [XLEN-1:0]  target, correct;
   logic [IDX_W-1:0] widx;
   logic             unused_pc_bits;

   assign unused_pc_bits = ^{f_pc[XLEN-1:IDX_W], ex_pc[XLEN-1:IDX_W]};
   // Plain array read: a same-cycle update is not visible until after the edge.
   assign f_pred_taken = bht[f_pc[IDX_W-1:0]][1];

   always_comb begin
      acc  = ex_valid & ~stall;
      widx = ex_pc[IDX_W-1:0];
      case (ex_funct3)
         3'b000:  cond = ex_zero;
         3'b001:  cond = ~ex_zero;
         3'b100:  cond = ex_lt;
         3'b101:  cond = ~ex_lt;
         3'b110:  cond = ex_ltu;
         3'b111:  cond = ~ex_ltu;
         default: cond = 1'b0;
      endcase
      target        = ex_jalr ? ex_alu_result : ex_pc + XLEN'($signed(ex_imm) >>> IMM_SHIFT);
      taken         = ex_jal | ex_jalr | (ex_branch & cond);
      need_redirect = (ex_jal | ex_jalr) ? 1'b1 : ex_branch ? (taken != ex_pred_taken) : 1'b0;
      correct       = taken ? target : ex_pc + XLEN'(PC_INC);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
      end else if (acc & ex_branch) begin
         bht[widx] <= taken ? (bht[widx] == 2'b11 ? 2'b11 : bht[widx] + 2'b01)
                            : (bht[widx] == 2'b00 ? 2'b00 : bht[widx] - 2'b01);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         redirect      <= 1'b0;
         redirect_pc   <= '0;
         jump          <= 1'b0;
         next          <= '0;
         out_jal       <= 1'b0;
         out_jalr      <= 1'b0;
         br_count      <= '0;
         mispred_count <= '0;
      end else if (acc) begin
         redirect      <= need_redirect;
         redirect_pc   <= correct;
         jump          <= taken;
         next          <= target;
         out_jal       <= ex_jal;
         out_jalr      <= ex_jalr;
         br_count      <= br_count + CNT_W'(ex_branch & (br_count != '1));
         mispred_count <= mispred_count + CNT_W'(need_redirect & (mispred_count != '1));
      end else begin
         redirect <= 1'b0;
      end
   end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch resolver; adds a direct-mapped table of 2-bit saturating counters for fetch-stage prediction.
- Resolves conditional branches, JAL and JALR in EX and detects mispredictions.
- Issues a registered one-cycle redirect to fetch and keeps saturating branch/mispredict performance counters.
- Sits between ID/EX pipeline register (resolve side) and PC/fetch logic (predict side).

Parameters:
- XLEN, 32, width of PC, immediate, ALU result and targets
- BHT_ENTRIES, 64, predictor entries; power of two, ≥2; IDX_W = log2(BHT_ENTRIES)
- IMM_SHIFT, 2, arithmetic right shift applied to imm before adding to PC (word-addressed PC)
- PC_INC, 1, fall-through increment
- CTR_INIT, 2'b01, counter reset value (weakly not-taken)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- f_pc  in  XLEN  fetch PC for lookup
- f_pred_taken  out  1  combinational: bit[1] of counter at f_pc[IDX_W-1:0]
- ex_valid  in  1  EX slot holds a real instruction
- stall  in  1  EX held; resolution not accepted
- ex_jal  in  1  JAL
- ex_jalr  in  1  JALR
- ex_branch  in  1  conditional branch
- ex_funct3  in  3  branch type
- ex_zero  in  1  ALU result zero
- ex_lt  in  1  signed less-than
- ex_ltu  in  1  unsigned less-than
- ex_imm  in  XLEN  signed immediate
- ex_pc  in  XLEN  PC of EX instruction
- ex_alu_result  in  XLEN  JALR target
- ex_pred_taken  in  1  prediction carried down from fetch
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  XLEN  corrected fetch PC
- jump  out  1  registered resolved-taken
- next  out  XLEN  registered resolved target
- out_jal  out  1  registered ex_jal
- out_jalr  out  1  registered ex_jalr
- br_count  out  CNT_W  accepted conditional branches
- mispred_count  out  CNT_W  accepted redirects

Behaviour:
- Accept condition: acc = ex_valid & ~stall. No state changes when acc = 0, except redirect and the output register rule below.
- Condition decode, by funct3:
  - 000 BEQ: zero
  - 001 BNE: ~zero
  - 100 BLT: lt
  - 101 BGE: ~lt
  - 110 BLTU: ltu
  - 111 BGEU: ~ltu
  - 010/011: not taken
- Target:
  - jalr = 1 (priority over jal/branch): ex_alu_result
  - otherwise: ex_pc + ($signed(ex_imm) >>> IMM_SHIFT), truncated to XLEN; wrap-around allowed
- taken = jal | jalr | (branch & cond).
- need_redirect:
  - jal/jalr: always 1 (predictor covers conditional branches only)
  - branch: taken != ex_pred_taken
  - other: 0
- Redirect PC: correct = taken ? target : ex_pc + PC_INC.
- Latency: one cycle. On the edge with acc:
  - jump <= taken
  - next <= target
  - out_jal/out_jalr <= inputs
  - redirect <= need_redirect
  - redirect_pc <= correct
- Output register hold: when acc = 0, redirect <= 0 and all other outputs hold their values.
- BHT update: on acc & ex_branch, entry ex_pc[IDX_W-1:0] increments if taken (saturate at 11), else decrements (saturate at 00). JAL/JALR never update.
- Read-during-write: f_pred_taken reflects the pre-update value when f_pc and ex_pc share an index in the same cycle.
- Counters:
  - br_count +1 on acc & ex_branch
  - mispred_count +1 on acc & need_redirect
  - both saturate at all-ones, no wrap
- Reset (rst_n = 0 at edge): overrides any concurrent update, including mid-stall.
  - all BHT entries <= CTR_INIT
  - redirect, jump, out_jal, out_jalr <= 0
  - next, redirect_pc <= 0
  - counters <= 0

Test Plan:
- Reset, then f_pc = 5 → f_pred_taken = 0. BEQ at pc 0x10, imm 0x20, zero = 1, pred 0 → next cycle: redirect = 1, redirect_pc = next = 0x18, jump = 1; br_count = 1, mispred_count = 1; entry 0x10 = 10; redirect low the cycle after.
- BNE at pc 0x40, imm = -16 (0xFFFFFFF0), zero = 0, pred 1 → redirect = 0, next = 0x3C, jump = 1. Same with zero = 1 → redirect = 1, redirect_pc = 0x41.
- JALR with jal = 1 also set, alu_result 0x1234, pc 0x8 → next = 0x1234, out_jalr = 1, redirect = 1. BHT and br_count unchanged; mispred_count +1.
- Train index 3 taken 4 times → counter 11; one not-taken → 10 and f_pred_taken still 1. Same-cycle lookup of index 3 during the update returns the old value.
- stall = 1 with a valid mispredicted branch → redirect = 0, outputs held, no BHT/counter change. Release stall → resolution occurs exactly once.
- rst_n low for one cycle while a valid branch update is presented → all entries CTR_INIT, counters 0, redirect 0. CNT_W = 4: 20 mispredicts → mispred_count = 15.
